// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: states, opcodes, functs,
// ALU operation codes and datapath mux selects.
package mc_pkg;

    localparam int unsigned STATE_W = 4;
    localparam int unsigned OP_W    = 6;
    localparam int unsigned ALUOP_W = 4;
    localparam int unsigned SRCA_W  = 2;
    localparam int unsigned SRCB_W  = 3;
    localparam int unsigned SEL_W   = 2;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_REXE   = 4'd6,
        S_RWB    = 4'd7,
        S_IEXE   = 4'd8,
        S_IWB    = 4'd9,
        S_BRANCH = 4'd10,
        S_JUMP   = 4'd11,
        S_JAL    = 4'd12
    } state_t;

    localparam logic [ALUOP_W-1:0] ALU_AND = 4'b0000;
    localparam logic [ALUOP_W-1:0] ALU_OR  = 4'b0001;
    localparam logic [ALUOP_W-1:0] ALU_ADD = 4'b0010;
    localparam logic [ALUOP_W-1:0] ALU_SUB = 4'b0110;
    localparam logic [ALUOP_W-1:0] ALU_SEQ = 4'b0111;
    localparam logic [ALUOP_W-1:0] ALU_SRL = 4'b1000;
    localparam logic [ALUOP_W-1:0] ALU_SLT = 4'b1001;
    localparam logic [ALUOP_W-1:0] ALU_SLL = 4'b1011;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;
    localparam logic [OP_W-1:0] OP_JAL   = 6'b000011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_ADDIU = 6'b001001;
    localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
    localparam logic [OP_W-1:0] OP_LUI   = 6'b001111;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;

    localparam logic [OP_W-1:0] FN_SLL  = 6'b000000;
    localparam logic [OP_W-1:0] FN_SRL  = 6'b000010;
    localparam logic [OP_W-1:0] FN_ADDU = 6'b100001;
    localparam logic [OP_W-1:0] FN_SUBU = 6'b100011;
    localparam logic [OP_W-1:0] FN_AND  = 6'b100100;
    localparam logic [OP_W-1:0] FN_OR   = 6'b100101;
    localparam logic [OP_W-1:0] FN_SLT  = 6'b101010;

    localparam logic [SRCA_W-1:0] SRCA_PC    = 2'b00;
    localparam logic [SRCA_W-1:0] SRCA_A     = 2'b01;
    localparam logic [SRCA_W-1:0] SRCA_SHAMT = 2'b10;
    localparam logic [SRCA_W-1:0] SRCA_C16   = 2'b11;

    localparam logic [SRCB_W-1:0] SRCB_B     = 3'b000;
    localparam logic [SRCB_W-1:0] SRCB_FOUR  = 3'b001;
    localparam logic [SRCB_W-1:0] SRCB_SEXT  = 3'b010;
    localparam logic [SRCB_W-1:0] SRCB_ZEXT  = 3'b011;
    localparam logic [SRCB_W-1:0] SRCB_BOFF  = 3'b100;

    localparam logic [SEL_W-1:0] PCSRC_ALU    = 2'b00;
    localparam logic [SEL_W-1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [SEL_W-1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [SEL_W-1:0] REGDST_RT = 2'b00;
    localparam logic [SEL_W-1:0] REGDST_RD = 2'b01;
    localparam logic [SEL_W-1:0] REGDST_RA = 2'b10;

    localparam logic [SEL_W-1:0] M2R_ALUOUT = 2'b00;
    localparam logic [SEL_W-1:0] M2R_MDR    = 2'b01;
    localparam logic [SEL_W-1:0] M2R_PC     = 2'b10;

    // R-type functs this controller can execute
    function automatic logic funct_ok(input logic [OP_W-1:0] funct);
        case (funct)
            FN_SLL, FN_SRL, FN_ADDU, FN_SUBU, FN_AND, FN_OR, FN_SLT: funct_ok = 1'b1;
            default:                                                 funct_ok = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mc_alu_dec.sv
// ALU-side decode: maps the current state and instruction fields onto
// ALUOp and the two ALU operand selects.
module mc_alu_dec
    import mc_pkg::*;
(
    input  state_t              state,
    input  logic [OP_W-1:0]     op,
    input  logic [OP_W-1:0]     funct,
    output logic [ALUOP_W-1:0]  aluop,
    output logic [SRCA_W-1:0]   alusrca,
    output logic [SRCB_W-1:0]   alusrcb
);

    always_comb begin
        aluop   = ALU_AND;
        alusrca = SRCA_PC;
        alusrcb = SRCB_B;
        case (state)
            S_FETCH: begin
                alusrcb = SRCB_FOUR;
                aluop   = ALU_ADD;
            end
            S_DECODE: begin
                alusrcb = SRCB_BOFF;
                aluop   = ALU_ADD;
            end
            S_MEMADR: begin
                alusrca = SRCA_A;
                alusrcb = SRCB_SEXT;
                aluop   = ALU_ADD;
            end
            S_REXE: begin
                alusrca = SRCA_A;
                case (funct)
                    FN_SUBU: aluop = ALU_SUB;
                    FN_AND:  aluop = ALU_AND;
                    FN_OR:   aluop = ALU_OR;
                    FN_SLT:  aluop = ALU_SLT;
                    // shifts take shamt on A; the ALU shifts B by A
                    FN_SLL: begin
                        aluop   = ALU_SLL;
                        alusrca = SRCA_SHAMT;
                    end
                    FN_SRL: begin
                        aluop   = ALU_SRL;
                        alusrca = SRCA_SHAMT;
                    end
                    default: aluop = ALU_ADD;
                endcase
            end
            S_IEXE: begin
                case (op)
                    OP_ORI: begin
                        alusrca = SRCA_A;
                        alusrcb = SRCB_ZEXT;
                        aluop   = ALU_OR;
                    end
                    OP_LUI: begin
                        alusrca = SRCA_C16;
                        alusrcb = SRCB_ZEXT;
                        aluop   = ALU_SLL;
                    end
                    default: begin
                        alusrca = SRCA_A;
                        alusrcb = SRCB_SEXT;
                        aluop   = ALU_ADD;
                    end
                endcase
            end
            S_BRANCH: begin
                alusrca = SRCA_A;
                aluop   = ALU_SEQ;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS main controller: sequences FETCH..WB, stalls on the
// MemReq/MemReady handshake and drives datapath enables and selects.
module mc_ctrl
    import mc_pkg::*;
#(
    parameter logic [STATE_W-1:0] RESET_STATE = 4'd0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [OP_W-1:0]     Op,
    input  logic [OP_W-1:0]     Funct,
    input  logic                CmpTrue,
    input  logic                MemReady,
    output logic                MemReq,
    output logic                MemWrite,
    output logic                IorD,
    output logic                IRWrite,
    output logic                PCWrite,
    output logic [SEL_W-1:0]    PCSrc,
    output logic                RegWrite,
    output logic [SEL_W-1:0]    RegDst,
    output logic [SEL_W-1:0]    MemtoReg,
    output logic [SRCA_W-1:0]   ALUSrcA,
    output logic [SRCB_W-1:0]   ALUSrcB,
    output logic [ALUOP_W-1:0]  ALUOp,
    output logic                Illegal,
    output logic [STATE_W-1:0]  State
);

    state_t state_q, state_d;
    logic   memreq_c, memwrite_c, irwrite_c, pcwrite_c, regwrite_c, illegal_c;

    always_ff @(posedge clk) begin
        if (reset) state_q <= state_t'(RESET_STATE);
        else       state_q <= state_d;
    end

    // Next state and state-decoded enables; FETCH/BRANCH also look at live inputs
    always_comb begin
        state_d    = S_FETCH;
        memreq_c   = 1'b0;
        memwrite_c = 1'b0;
        irwrite_c  = 1'b0;
        pcwrite_c  = 1'b0;
        regwrite_c = 1'b0;
        illegal_c  = 1'b0;
        IorD       = 1'b0;
        PCSrc      = PCSRC_ALU;
        RegDst     = REGDST_RT;
        MemtoReg   = M2R_ALUOUT;
        case (state_q)
            S_FETCH: begin
                memreq_c  = 1'b1;
                irwrite_c = MemReady;
                pcwrite_c = MemReady;
                state_d   = MemReady ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                case (Op)
                    OP_RTYPE: begin
                        if (funct_ok(Funct)) state_d = S_REXE;
                        else                 illegal_c = 1'b1;
                    end
                    OP_LW, OP_SW:             state_d = S_MEMADR;
                    OP_ADDIU, OP_ORI, OP_LUI: state_d = S_IEXE;
                    OP_BEQ:                   state_d = S_BRANCH;
                    OP_J:                     state_d = S_JUMP;
                    OP_JAL:                   state_d = S_JAL;
                    default:                  illegal_c = 1'b1;
                endcase
            end
            S_MEMADR: state_d = (Op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD: begin
                memreq_c = 1'b1;
                IorD     = 1'b1;
                state_d  = MemReady ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                regwrite_c = 1'b1;
                MemtoReg   = M2R_MDR;
            end
            S_MEMWR: begin
                memreq_c   = 1'b1;
                memwrite_c = 1'b1;
                IorD       = 1'b1;
                state_d    = MemReady ? S_FETCH : S_MEMWR;
            end
            S_REXE: state_d = S_RWB;
            S_RWB: begin
                regwrite_c = 1'b1;
                RegDst     = REGDST_RD;
            end
            S_IEXE: state_d = S_IWB;
            S_IWB:  regwrite_c = 1'b1;
            S_BRANCH: begin
                pcwrite_c = CmpTrue;
                PCSrc     = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                pcwrite_c = 1'b1;
                PCSrc     = PCSRC_JUMP;
            end
            S_JAL: begin
                pcwrite_c  = 1'b1;
                PCSrc      = PCSRC_JUMP;
                regwrite_c = 1'b1;
                RegDst     = REGDST_RA;
                MemtoReg   = M2R_PC;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Reset squashes every side effect immediately, even mid memory wait
    assign MemReq   = memreq_c   & ~reset;
    assign MemWrite = memwrite_c & ~reset;
    assign IRWrite  = irwrite_c  & ~reset;
    assign PCWrite  = pcwrite_c  & ~reset;
    assign RegWrite = regwrite_c & ~reset;
    assign Illegal  = illegal_c  & ~reset;
    assign State    = state_q;

    mc_alu_dec u_alu_dec (
        .state   (state_q),
        .op      (Op),
        .funct   (Funct),
        .aluop   (ALUOp),
        .alusrca (ALUSrcA),
        .alusrcb (ALUSrcB)
    );

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: each cycle's expected outputs are queued by the
// driver and checked by an independent monitor on the falling edge.
module tb_mc_ctrl;
    import mc_pkg::*;

    typedef struct packed {
        logic [3:0] st;
        logic       mreq;
        logic       mwr;
        logic       iord;
        logic       irw;
        logic       pcw;
        logic [1:0] pcsrc;
        logic       rw;
        logic [1:0] rdst;
        logic [1:0] m2r;
        logic [1:0] sa;
        logic [2:0] sb;
        logic [3:0] aop;
        logic       ill;
    } out_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] Op, Funct;
    logic       CmpTrue, MemReady;
    logic       MemReq, MemWrite, IorD, IRWrite, PCWrite, RegWrite, Illegal;
    logic [1:0] PCSrc, RegDst, MemtoReg, ALUSrcA;
    logic [2:0] ALUSrcB;
    logic [3:0] ALUOp, State;

    out_t  exp_q[$];
    string name_q[$];
    int    checks   = 0;
    int    failures = 0;

    always #5 clk = ~clk;

    mc_ctrl dut (
        .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .CmpTrue(CmpTrue),
        .MemReady(MemReady), .MemReq(MemReq), .MemWrite(MemWrite), .IorD(IorD),
        .IRWrite(IRWrite), .PCWrite(PCWrite), .PCSrc(PCSrc), .RegWrite(RegWrite),
        .RegDst(RegDst), .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUOp(ALUOp), .Illegal(Illegal), .State(State)
    );

    function automatic out_t e(input logic [3:0] st, input logic mreq, input logic mwr,
                               input logic iord, input logic irw, input logic pcw,
                               input logic [1:0] pcsrc, input logic rw, input logic [1:0] rdst,
                               input logic [1:0] m2r, input logic [1:0] sa, input logic [2:0] sb,
                               input logic [3:0] aop, input logic ill);
        return {st, mreq, mwr, iord, irw, pcw, pcsrc, rw, rdst, m2r, sa, sb, aop, ill};
    endfunction

    // Common expectations for FETCH and DECODE cycles
    function automatic out_t x_fetch(input logic rdy);
        return e(S_FETCH, 1, 0, 0, rdy, rdy, 2'b00, 0, 2'b00, 2'b00, 2'b00, 3'b001, ALU_ADD, 0);
    endfunction
    function automatic out_t x_dec(input logic ill);
        return e(S_DECODE, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 2'b00, 3'b100, ALU_ADD, ill);
    endfunction

    task automatic step(input logic [5:0] op, input logic [5:0] fn, input logic cmp,
                        input logic rdy, input logic rst, input string nm, input out_t x);
        @(posedge clk);
        #1;
        Op = op; Funct = fn; CmpTrue = cmp; MemReady = rdy; reset = rst;
        exp_q.push_back(x);
        name_q.push_back(nm);
    endtask

    // Monitor: compares the oldest queued expectation against the live outputs
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            out_t  x, act;
            string nm;
            x   = exp_q.pop_front();
            nm  = name_q.pop_front();
            act = {State, MemReq, MemWrite, IorD, IRWrite, PCWrite, PCSrc, RegWrite,
                   RegDst, MemtoReg, ALUSrcA, ALUSrcB, ALUOp, Illegal};
            checks++;
            if (act !== x) begin
                failures++;
                $display("FAIL %s: got=%h (state %0d) expected=%h (state %0d)",
                         nm, act, act.st, x, x.st);
            end
        end
    end

    initial begin
        reset = 1'b1; Op = '0; Funct = '0; CmpTrue = 1'b0; MemReady = 1'b1;

        step(6'h00, 6'h21, 0, 1, 1, "reset0", e(S_FETCH, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 2'b00, 3'b001, ALU_ADD, 0));
        step(6'h00, 6'h21, 0, 1, 1, "reset1", e(S_FETCH, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 2'b00, 3'b001, ALU_ADD, 0));

        // addu
        step(OP_RTYPE, FN_ADDU, 0, 1, 0, "addu_fetch", x_fetch(1));
        step(OP_RTYPE, FN_ADDU, 0, 1, 0, "addu_dec",   x_dec(0));
        step(OP_RTYPE, FN_ADDU, 0, 1, 0, "addu_rexe",  e(S_REXE, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 2'b01, 3'b000, ALU_ADD, 0));
        step(OP_RTYPE, FN_ADDU, 0, 1, 0, "addu_rwb",   e(S_RWB, 0, 0, 0, 0, 0, 2'b00, 1, 2'b01, 2'b00, 2'b00, 3'b000, ALU_AND, 0));

        // lw with three MemReady-low cycles in MEMRD
        step(OP_LW, 6'h00, 0, 1, 0, "lw_fetch",  x_fetch(1));
        step(OP_LW, 6'h00, 0, 1, 0, "lw_dec",    x_dec(0));
        step(OP_LW, 6'h00, 0, 1, 0, "lw_memadr", e(S_MEMADR, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 2'b01, 3'b010, ALU_ADD, 0));
        for (int i = 0; i < 3; i++)
            step(OP_LW, 6'h00, 0, 0, 0, "lw_memrd_wait", e(S_MEMRD, 1, 0, 1, 0, 0, 2'b00, 0, 2'b00, 2'b00, 2'b00, 3'b000, ALU_AND, 0));
        step(OP_LW, 6'h00, 0, 1, 0, "lw_memrd_done", e(S_MEMRD, 1, 0, 1, 0, 0, 2'b00, 0, 2'b00, 2'b00, 2'b00, 3'b000, ALU_AND, 0));
        step(OP_LW, 6'h00, 0, 1, 0, "lw_memwb",  e(S_MEMWB, 0, 0, 0, 0, 0, 2'b00, 1, 2'b00, 2'b01, 2'b00, 3'b000, ALU_AND, 0));

        // beq taken then not taken
        step(OP_BEQ, 6'h00, 1, 1, 0, "beq1_fetch", x_fetch(1));
        step(OP_BEQ, 6'h00, 1, 1, 0, "beq1_dec",   x_dec(0));
        step(OP_BEQ, 6'h00, 1, 1, 0, "beq1_br",    e(S_BRANCH, 0, 0, 0, 0, 1, 2'b01, 0, 2'b00, 2'b00, 2'b01, 3'b000, ALU_SEQ, 0));
        step(OP_BEQ, 6'h00, 0, 1, 0, "beq0_fetch", x_fetch(1));
        step(OP_BEQ, 6'h00, 0, 1, 0, "beq0_dec",   x_dec(0));
        step(OP_BEQ, 6'h00, 0, 1, 0, "beq0_br",    e(S_BRANCH, 0, 0, 0, 0, 0, 2'b01, 0, 2'b00, 2'b00, 2'b01, 3'b000, ALU_SEQ, 0));

        // lui and ori
        step(OP_LUI, 6'h00, 0, 1, 0, "lui_fetch", x_fetch(1));
        step(OP_LUI, 6'h00, 0, 1, 0, "lui_dec",   x_dec(0));
        step(OP_LUI, 6'h00, 0, 1, 0, "lui_iexe",  e(S_IEXE, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 2'b11, 3'b011, ALU_SLL, 0));
        step(OP_LUI, 6'h00, 0, 1, 0, "lui_iwb",   e(S_IWB, 0, 0, 0, 0, 0, 2'b00, 1, 2'b00, 2'b00, 2'b00, 3'b000, ALU_AND, 0));
        step(OP_ORI, 6'h00, 0, 1, 0, "ori_fetch", x_fetch(1));
        step(OP_ORI, 6'h00, 0, 1, 0, "ori_dec",   x_dec(0));
        step(OP_ORI, 6'h00, 0, 1, 0, "ori_iexe",  e(S_IEXE, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 2'b01, 3'b011, ALU_OR, 0));
        step(OP_ORI, 6'h00, 0, 1, 0, "ori_iwb",   e(S_IWB, 0, 0, 0, 0, 0, 2'b00, 1, 2'b00, 2'b00, 2'b00, 3'b000, ALU_AND, 0));

        // sll and srl
        step(OP_RTYPE, FN_SLL, 0, 1, 0, "sll_fetch", x_fetch(1));
        step(OP_RTYPE, FN_SLL, 0, 1, 0, "sll_dec",   x_dec(0));
        step(OP_RTYPE, FN_SLL, 0, 1, 0, "sll_rexe",  e(S_REXE, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 2'b10, 3'b000, ALU_SLL, 0));
        step(OP_RTYPE, FN_SLL, 0, 1, 0, "sll_rwb",   e(S_RWB, 0, 0, 0, 0, 0, 2'b00, 1, 2'b01, 2'b00, 2'b00, 3'b000, ALU_AND, 0));
        step(OP_RTYPE, FN_SRL, 0, 1, 0, "srl_fetch", x_fetch(1));
        step(OP_RTYPE, FN_SRL, 0, 1, 0, "srl_dec",   x_dec(0));
        step(OP_RTYPE, FN_SRL, 0, 1, 0, "srl_rexe",  e(S_REXE, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 2'b10, 3'b000, ALU_SRL, 0));
        step(OP_RTYPE, FN_SRL, 0, 1, 0, "srl_rwb",   e(S_RWB, 0, 0, 0, 0, 0, 2'b00, 1, 2'b01, 2'b00, 2'b00, 3'b000, ALU_AND, 0));

        // Illegal opcode and illegal funct: single-cycle pulse, back to FETCH
        step(6'h3F, 6'h00, 0, 1, 0, "illop_fetch", x_fetch(1));
        step(6'h3F, 6'h00, 0, 1, 0, "illop_dec",   x_dec(1));
        step(OP_RTYPE, 6'h08, 0, 1, 0, "illfn_fetch", x_fetch(1));
        step(OP_RTYPE, 6'h08, 0, 1, 0, "illfn_dec",   x_dec(1));

        // j
        step(OP_J, 6'h00, 0, 1, 0, "j_fetch", x_fetch(1));
        step(OP_J, 6'h00, 0, 1, 0, "j_dec",   x_dec(0));
        step(OP_J, 6'h00, 0, 1, 0, "j_jump",  e(S_JUMP, 0, 0, 0, 0, 1, 2'b10, 0, 2'b00, 2'b00, 2'b00, 3'b000, ALU_AND, 0));

        // sw with a fetch stall, then reset while waiting in MEMWR
        step(OP_SW, 6'h00, 0, 0, 0, "sw_fetch_wait", x_fetch(0));
        step(OP_SW, 6'h00, 0, 1, 0, "sw_fetch",      x_fetch(1));
        step(OP_SW, 6'h00, 0, 1, 0, "sw_dec",        x_dec(0));
        step(OP_SW, 6'h00, 0, 1, 0, "sw_memadr",     e(S_MEMADR, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 2'b01, 3'b010, ALU_ADD, 0));
        step(OP_SW, 6'h00, 0, 0, 0, "sw_memwr_wait", e(S_MEMWR, 1, 1, 1, 0, 0, 2'b00, 0, 2'b00, 2'b00, 2'b00, 3'b000, ALU_AND, 0));
        step(OP_SW, 6'h00, 0, 0, 1, "sw_memwr_rst",  e(S_MEMWR, 0, 0, 1, 0, 0, 2'b00, 0, 2'b00, 2'b00, 2'b00, 3'b000, ALU_AND, 0));

        // jal after reset
        step(OP_JAL, 6'h00, 0, 1, 0, "jal_fetch", x_fetch(1));
        step(OP_JAL, 6'h00, 0, 1, 0, "jal_dec",   x_dec(0));
        step(OP_JAL, 6'h00, 0, 1, 0, "jal_jal",   e(S_JAL, 0, 0, 0, 0, 1, 2'b10, 1, 2'b10, 2'b10, 2'b00, 3'b000, ALU_AND, 0));
        step(OP_JAL, 6'h00, 0, 0, 0, "end_fetch", x_fetch(0));

        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: got=%0d pending expected=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
